// File: rtl/fifo_tx_pkg.sv
// Shared types and width helpers for the FIFO-draining UART transmitter.
// Optional parity support is selected with FIFO_TX_PARITY_EN.
package fifo_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Width of the per-bit clock counter (0..clks-1), at least 1 bit
    function automatic int bit_cnt_w(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

    // Width of the data-bit index counter (0..width-1), at least 1 bit
    function automatic int idx_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: bit_cnt runs 0..CLKS_PER_BIT-1, bit_tick on the last count.
// A synchronous clear realigns the period to a state change.
module baud_tick_gen
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CW           = bit_cnt_w(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    output logic [CW-1:0] bit_cnt,
    output logic          bit_tick
);

    assign bit_tick = (bit_cnt == CW'(CLKS_PER_BIT - 1));

    // Free-running count, wrapping at the end of each bit or on clear
    always_ff @(posedge clk or posedge res) begin
        if (res)
            bit_cnt <= '0;
        else if (clr || bit_tick)
            bit_cnt <= '0;
        else
            bit_cnt <= bit_cnt + 1'b1;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FIFO and sends each as start, data LSB first, [parity], stop.
// Define FIFO_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_shift_out,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int   CW        = bit_cnt_w(CLKS_PER_BIT);
    localparam int   IW        = idx_w(WIDTH);
    localparam logic LAST_STOP = (STOP_BITS == 2);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [IW-1:0]    idx, idx_n;
    logic             stop_idx, stop_idx_n;
    logic             last_stop;
    logic [CW-1:0]    bit_cnt;
    logic             bit_tick;
    logic             pop;
    logic             tx_n, busy_n, done_n;
`ifdef FIFO_TX_PARITY_EN
    logic             par, par_n;
`endif

    assign last_stop = (stop_idx == LAST_STOP);

    // Pop from idle, or in the final clk of the last stop bit for a zero gap
    assign pop = ~res & enable & ~fifo_empty &
                 ((state == ST_IDLE) |
                  ((state == ST_STOP) & last_stop & bit_tick));

    assign fifo_shift_out = pop;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_tick (
        .clk      (clk),
        .res      (res),
        .clr      (state_n != state),
        .bit_cnt  (bit_cnt),
        .bit_tick (bit_tick)
    );

    // Next-state, datapath and registered-output values
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        idx_n      = idx;
        stop_idx_n = stop_idx;
`ifdef FIFO_TX_PARITY_EN
        par_n      = par;
`endif
        case (state)
            ST_IDLE: begin
                if (pop)
                    state_n = ST_START;
            end
            ST_START: begin
                if (bit_tick)
                    state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_n = shreg >> 1;
                    idx_n   = idx + 1'b1;
                    if (idx == IW'(WIDTH - 1)) begin
`ifdef FIFO_TX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                        stop_idx_n = 1'b0;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_n    = ST_STOP;
                    stop_idx_n = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (!last_stop)
                        stop_idx_n = 1'b1;
                    else if (pop)
                        state_n = ST_START;
                    else
                        state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (pop) begin
            shreg_n = fifo_rdata;
            idx_n   = '0;
`ifdef FIFO_TX_PARITY_EN
            par_n   = ^fifo_rdata;
`endif
        end

        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = shreg_n[0];
`ifdef FIFO_TX_PARITY_EN
            ST_PARITY: tx_n = par_n;
`endif
            default:   tx_n = 1'b1;
        endcase

        busy_n = (state_n != ST_IDLE);
        // Next clk is the final clk of the last stop bit
        done_n = (state == ST_STOP) & last_stop &
                 (bit_cnt == CW'(CLKS_PER_BIT - 2));
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            idx      <= idx_n;
            stop_idx <= stop_idx_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

`ifdef FIFO_TX_PARITY_EN
    // Parity of the word captured at the pop
    always_ff @(posedge clk or posedge res) begin
        if (res)
            par <= 1'b0;
        else
            par <= par_n;
    end
`endif

endmodule
